// File: rtl/monopix_hit_buffer_pkg.sv
// monopix_pkg: shared hit-word types, widths and Gray decode for the hit buffer
package monopix_pkg;
  localparam int HIT_WORD_W = 32;
  localparam int DATA_W = 27;
  typedef struct packed {
    logic [5:0] col;
    logic [5:0] te;
    logic [5:0] le;
    logic [8:0] row;
  } t_data;
  typedef struct packed {
    logic [5:0] col;
    logic [8:0] row;
    logic [5:0] le;
    logic [5:0] tot;
    logic       lost;
    logic [3:0] rsvd;
  } t_hit_word;
  function automatic logic [5:0] gray2bin(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/monopix_sync_fifo.sv
// monopix_sync_fifo: single-clock first-word-fall-through FIFO with up/down occupancy count
module monopix_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk_out,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic w_rd, w_wr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign w_rd = rd_en & !empty;
  // a write into a full FIFO is accepted only when the head leaves on the same edge
  assign w_wr = wr_en & (!full | w_rd);
  assign rd_data = empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk_out) begin
    if (w_wr) r_mem[r_wr] <= wr_data;
  end
  always_ff @(posedge clk_out) begin
    if (reset) begin
      r_rd <= '0;
      r_wr <= '0;
      count <= '0;
    end else begin
      r_rd <= r_rd + AW'(w_rd);
      r_wr <= r_wr + AW'(w_wr);
      count <= count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/monopix_hit_buffer.sv
// monopix_hit_buffer: Gray LE/TE decode, ToT computation and FWFT buffering of packed hit words
module monopix_hit_buffer
  import monopix_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk_out,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   data_in_strobe,
  output logic [HIT_WORD_W-1:0]  hit_data,
  output logic                   hit_valid,
  input  logic                   hit_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_WIDTH-1:0]   overflow_cnt
);
  t_data w_d;
  t_hit_word r_s1, w_wr_word;
  logic r_s1_valid, r_lost, w_pop, w_drop, w_wr;
  logic [5:0] w_le, w_te;
  assign w_d = t_data'(data_in);
  assign w_le = gray2bin(w_d.le);
  assign w_te = gray2bin(w_d.te);
  assign hit_valid = !empty;
  assign w_pop = hit_valid & hit_ready;
  assign w_drop = r_s1_valid & full & !w_pop;
  assign w_wr = r_s1_valid & !w_drop;
  // the lost flag is attached at write time so it lands on the next word actually stored
  always_comb begin
    w_wr_word = r_s1;
    w_wr_word.lost = r_lost;
  end
  always_ff @(posedge clk_out) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1 <= '0;
      r_lost <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      r_s1_valid <= data_in_strobe;
      if (data_in_strobe)
        r_s1 <= '{col: w_d.col, row: w_d.row, le: w_le, tot: w_te - w_le, lost: 1'b0, rsvd: 4'b0};
      r_lost <= w_drop | (r_lost & !w_wr);
      if (w_drop && !(&overflow_cnt)) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end
  monopix_sync_fifo #(.WIDTH(HIT_WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk_out(clk_out),
    .reset(reset),
    .wr_en(w_wr),
    .wr_data(w_wr_word),
    .rd_en(hit_ready),
    .rd_data(hit_data),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_monopix_hit_buffer.sv
// tb_monopix_hit_buffer: scoreboard bench with a queue-level reference model of the hit buffer
module tb_monopix_hit_buffer;
  localparam int DEPTH = 16;
  logic clk_out = 1'b0, reset = 1'b1, data_in_strobe = 1'b0, hit_ready = 1'b0;
  logic [26:0] data_in = '0;
  logic [31:0] hit_data;
  logic hit_valid, full, empty;
  logic [4:0] fifo_count;
  logic [15:0] overflow_cnt;
  int errors = 0, checks = 0;
  logic [31:0] exp_q[$];
  logic m_v = 1'b0, m_lost = 1'b0;
  logic [26:0] m_d = '0;
  int m_cnt = 0, m_ovf = 0;

  monopix_hit_buffer #(.DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk_out(clk_out), .reset(reset), .data_in(data_in), .data_in_strobe(data_in_strobe),
    .hit_data(hit_data), .hit_valid(hit_valid), .hit_ready(hit_ready), .fifo_count(fifo_count),
    .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [5:0] g2b(input logic [5:0] g);
    logic [5:0] b = '0;
    for (int s = 0; s < 6; s++) b ^= g >> s;
    return b;
  endfunction

  function automatic logic [31:0] exp_word(input logic [26:0] d, input logic l);
    logic [5:0] lb = g2b(d[14:9]);
    logic [5:0] tb = g2b(d[20:15]);
    int t = (int'(tb) - int'(lb) + 64) % 64;
    return {d[26:21], d[8:0], lb, 6'(t), l, 4'b0000};
  endfunction

  function automatic logic [26:0] mk(input logic [5:0] col, input logic [8:0] row,
                                     input logic [5:0] le_g, input logic [5:0] te_g);
    return {col, te_g, le_g, row};
  endfunction

  // reference model: stage register, occupancy, drop/lost bookkeeping; pushes expected words
  always @(posedge clk_out) begin
    if (reset) begin
      m_v = 1'b0; m_lost = 1'b0; m_cnt = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      automatic bit pop = m_cnt > 0 && hit_ready;
      if (m_v) begin
        if (m_cnt < DEPTH || pop) begin
          exp_q.push_back(exp_word(m_d, m_lost));
          m_lost = 1'b0;
          m_cnt++;
        end else begin
          m_lost = 1'b1;
          if (m_ovf < 65535) m_ovf++;
        end
      end
      if (pop) m_cnt--;
      m_v = data_in_strobe;
      m_d = data_in;
    end
  end

  // monitor: compares status every cycle and the head word on each handshake
  always @(negedge clk_out) begin
    if (!reset) begin
      chk("fifo_count", 32'(fifo_count), 32'(m_cnt));
      chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
      chk("hit_valid", 32'(hit_valid), 32'(m_cnt != 0));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      if (!hit_valid) chk("hit_data_idle", hit_data, 32'h0);
      if (hit_valid && hit_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pop", hit_data, 32'hdeadbeef);
        else chk("pop_word", hit_data, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic s, input logic [26:0] d, input logic r);
    data_in_strobe = s;
    data_in = d;
    hit_ready = r;
    @(posedge clk_out);
    #2;
  endtask

  initial begin
    @(posedge clk_out); #2;
    drive(1'b1, mk(1, 1, 1, 1), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("rst_valid", 32'(hit_valid), 0);
    chk("rst_data", hit_data, 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ovf", 32'(overflow_cnt), 0);
    reset = 1'b0;
    // single hit: Gray 15 -> 10, Gray 25 -> 17
    drive(1'b1, mk(5, 100, 15, 25), 1'b0);
    chk("lat_not_yet", 32'(hit_valid), 0);
    drive(1'b0, '0, 1'b0);
    chk("lat_valid", 32'(hit_valid), 1);
    chk("single_col", 32'(hit_data[31:26]), 5);
    chk("single_row", 32'(hit_data[25:17]), 100);
    chk("single_le", 32'(hit_data[16:11]), 10);
    chk("single_tot", 32'(hit_data[10:5]), 7);
    chk("single_lost", 32'(hit_data[4:0]), 0);
    chk("single_count", 32'(fifo_count), 1);
    drive(1'b0, '0, 1'b1);
    // ToT wrap: Gray 34 -> 60, Gray 2 -> 3
    drive(1'b1, mk(9, 7, 34, 2), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("wrap_le", 32'(hit_data[16:11]), 60);
    chk("wrap_tot", 32'(hit_data[10:5]), 7);
    drive(1'b0, '0, 1'b1);
    // fill and overflow
    for (int i = 0; i < 16; i++) drive(1'b1, mk(6'(i), 9'(i), 6'(i), 6'(i + 3)), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(fifo_count), 16);
    for (int i = 0; i < 3; i++) drive(1'b1, mk(6'h3f, 9'h1ff, 6'(i), 0), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("ovf_cnt", 32'(overflow_cnt), 3);
    chk("ovf_count", 32'(fifo_count), 16);
    for (int i = 0; i < 16; i++) drive(1'b0, '0, 1'b1);
    chk("drained", 32'(empty), 1);
    drive(1'b1, mk(2, 200, 4, 9), 1'b0);
    drive(1'b1, mk(3, 201, 5, 6), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("lost_set", 32'(hit_data[4]), 1);
    drive(1'b0, '0, 1'b1);
    chk("lost_clear", 32'(hit_data[4]), 0);
    drive(1'b0, '0, 1'b1);
    // push and pop while full
    reset = 1'b1; drive(1'b0, '0, 1'b0); reset = 1'b0;
    for (int i = 0; i < 16; i++) drive(1'b1, mk(6'(i), 9'(i + 300), 6'(i), 6'(i)), 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, mk(1, 400, 1, 2), 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, mk(6'(i), 9'(i + 401), 6'(2 * i), 6'(i)), 1'b1);
      chk("pp_count", 32'(fifo_count), 16);
      chk("pp_ovf", 32'(overflow_cnt), 0);
    end
    for (int i = 0; i < 40 && !(empty && !m_v); i++) drive(1'b0, '0, 1'b1);
    chk("pp_drain", 32'(empty), 1);
    // back-to-back streaming
    drive(1'b1, mk(0, 0, 0, 0), 1'b1);
    chk("bb_first", 32'(hit_valid), 0);
    for (int i = 1; i < 9; i++) begin
      drive(i < 8, mk(6'(i), 9'(i), 6'(i), 0), 1'b1);
      chk("bb_valid", 32'(hit_valid), 1);
      chk("bb_row", 32'(hit_data[25:17]), i - 1);
    end
    drive(1'b0, '0, 1'b1);
    chk("bb_done", 32'(hit_valid), 0);
    // reset mid-operation
    for (int i = 0; i < 6; i++) drive(1'b1, mk(7, 9'(i + 50), 3, 4), 1'b0);
    chk("mid_count", 32'(fifo_count), 5);
    reset = 1'b1;
    drive(1'b1, mk(8, 60, 3, 4), 1'b0);
    reset = 1'b0;
    chk("mr_valid", 32'(hit_valid), 0);
    chk("mr_count", 32'(fifo_count), 0);
    chk("mr_ovf", 32'(overflow_cnt), 0);
    chk("mr_empty", 32'(empty), 1);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
    chk("mr_no_ghost", 32'(hit_valid), 0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 7, 27'($urandom), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 100 && !(empty && !m_v); i++) drive(1'b0, '0, 1'b1);
    chk("final_empty", 32'(empty), 1);
    chk("final_sb", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
